setup_param: RTL and testbench

SETUP_PARAM -- requirements
Module: setup_param

---
 rtl/setup_pkg.sv | 63 ++++++
 rtl/setup_entry_buf.sv | 54 +++++
 rtl/setup_param.sv | 205 ++++++++++++++++++++
 tb/tb_setup_param.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/setup_pkg.sv
// Shared types and constants for the setup-mode controller: display packet,
// password packet, configuration record, key codes and FSM states.
package setup_pkg;

    localparam int MAX_PASS  = 12;
    localparam int MAX_USERS = 8;

    localparam logic [3:0] KEY_A = 4'hA;
    localparam logic [3:0] KEY_B = 4'hB;
    localparam logic [3:0] BLANK = 4'hF;

    // Index 5 is BCD5 (option index), indices 4..0 are the entry digits
    typedef logic [5:0][3:0] bcdPac_t;

    // Right-aligned digits: index 0 is the most recently typed digit, unused nibbles are 0xF
    typedef logic [MAX_PASS-1:0][3:0] senhaPac_t;

    typedef struct packed {
        logic                        bip_status;
        logic [6:0]                  bip_time;
        logic [6:0]                  tranca_aut_time;
        senhaPac_t                   senha_master;
        senhaPac_t [MAX_USERS-1:0]   senha_user;
    } setupPac_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARMED  = 3'd1,
        S_EDIT   = 3'd2,
        S_COMMIT = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam bcdPac_t   BCD_BLANK     = {6{4'hF}};
    localparam senhaPac_t SENHA_OFF     = {MAX_PASS{4'hF}};
    localparam senhaPac_t SENHA_DEFAULT = {{(MAX_PASS-4){4'hF}}, 4'h1, 4'h2, 4'h3, 4'h4};

    function automatic logic [6:0] clamp7(input logic [6:0] v, input logic [6:0] lo,
                                          input logic [6:0] hi);
        logic [6:0] r;
        if (v < lo) begin
            r = lo;
        end else if (v > hi) begin
            r = hi;
        end else begin
            r = v;
        end
        return r;
    endfunction

    function automatic setupPac_t setup_default();
        setupPac_t s;
        s.bip_status      = 1'b1;
        s.bip_time        = 7'd5;
        s.tranca_aut_time = 7'd5;
        s.senha_master    = SENHA_DEFAULT;
        for (int i = 0; i < MAX_USERS; i++) begin
            s.senha_user[i] = SENHA_OFF;
        end
        return s;
    endfunction

endpackage

// File: rtl/setup_entry_buf.sv
// Keypad digit buffer: shifts digits in, counts them, and drops digits once
// PASS_MAX are held. Also exposes the next low five digits for the display.
module setup_entry_buf
    import setup_pkg::*;
#(
    parameter int PASS_MAX = 12
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            push,
    input  logic [3:0]      digit,
    output senhaPac_t       digits,
    output logic [3:0]      count,
    output logic [4:0][3:0] view_nxt
);

    senhaPac_t  digits_r;
    senhaPac_t  digits_s;
    logic [3:0] count_r;
    logic [3:0] count_s;

    // Next buffer contents: clear wins over push, a full buffer ignores new digits
    always_comb begin
        digits_s = digits_r;
        count_s  = count_r;
        if (clr) begin
            digits_s = SENHA_OFF;
            count_s  = 4'd0;
        end else if (push && (count_r < 4'(PASS_MAX))) begin
            digits_s = {digits_r[MAX_PASS-2:0], digit};
            count_s  = count_r + 4'd1;
        end else begin
            digits_s = digits_r;
            count_s  = count_r;
        end
    end

    // Buffer state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_r <= SENHA_OFF;
            count_r  <= 4'd0;
        end else begin
            digits_r <= digits_s;
            count_r  <= count_s;
        end
    end

    assign digits   = digits_r;
    assign count    = count_r;
    assign view_nxt = digits_s[4:0];

endmodule

// File: rtl/setup_param.sv
// Keypad-driven setup controller: edits a working copy of the configuration and
// publishes it on key B. Define SETUP_TIMEOUT_EN to abort an idle session.
module setup_param
    import setup_pkg::*;
#(
    parameter int NUM_USERS      = 4,
    parameter int PASS_MAX       = 12,
    parameter int BIP_MIN        = 5,
    parameter int BIP_MAX        = 60,
    parameter int TRANCA_MIN     = 5,
    parameter int TRANCA_MAX     = 60,
    parameter int TIMEOUT_CYCLES = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       setup_on,
    input  logic [3:0] digitos_value,
    input  logic       digitos_valid,
    output logic       display_en,
    output bcdPac_t    bcd_pac,
    output setupPac_t  data_setup_new,
    output logic       data_setup_ok
);

    localparam logic [3:0] LAST_OPT = 4'(4 + NUM_USERS);

    if (NUM_USERS < 1 || NUM_USERS > MAX_USERS || PASS_MAX < 4 || PASS_MAX > MAX_PASS ||
        TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("setup_param: parameter out of range");
    end

    state_t          state_r;
    logic [3:0]      opt_r;
    setupPac_t       work_r;
    setupPac_t       setup_r;
    setupPac_t       work_commit_s;
    bcdPac_t         bcd_r;
    logic            display_en_r;
    logic            ok_r;

    logic            key_digit_s;
    logic            key_a_s;
    logic            key_b_s;
    logic            buf_clr_s;
    logic            buf_push_s;
    logic            timeout_s;
    logic            pass_ok_s;
    logic [2:0]      user_idx_s;
    logic [6:0]      num_s;
    senhaPac_t       ent_digits_s;
    logic [3:0]      ent_count_s;
    logic [4:0][3:0] view_nxt_s;
    logic [3:0]      opt_next_s;

    assign key_digit_s = digitos_valid && (digitos_value <= 4'd9);
    assign key_a_s     = digitos_valid && (digitos_value == KEY_A);
    assign key_b_s     = digitos_valid && (digitos_value == KEY_B);
    assign buf_push_s  = (state_r == S_EDIT) && key_digit_s;
    assign buf_clr_s   = (state_r == S_IDLE) || (state_r == S_COMMIT) ||
                         ((state_r == S_EDIT) && key_a_s) || timeout_s;
    assign opt_next_s  = (opt_r == LAST_OPT) ? 4'd1 : (opt_r + 4'd1);

    setup_entry_buf #(.PASS_MAX(PASS_MAX)) u_entry_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (buf_clr_s),
        .push     (buf_push_s),
        .digit    (digitos_value),
        .digits   (ent_digits_s),
        .count    (ent_count_s),
        .view_nxt (view_nxt_s)
    );

`ifdef SETUP_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle_cnt_r;

    // Counts consecutive cycles without a key strobe while a session is open
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_r <= '0;
        end else if (((state_r == S_ARMED) || (state_r == S_EDIT)) && !digitos_valid) begin
            idle_cnt_r <= idle_cnt_r + TW'(1);
        end else begin
            idle_cnt_r <= '0;
        end
    end

    assign timeout_s = ((state_r == S_ARMED) || (state_r == S_EDIT)) && !digitos_valid &&
                       (idle_cnt_r == TW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_s = 1'b0;
`endif

    // Two-digit numeric value: the digit before the last one is the tens place
    assign num_s      = (ent_count_s >= 4'd2) ?
                        (7'(ent_digits_s[1]) * 7'd10 + 7'(ent_digits_s[0])) :
                        7'(ent_digits_s[0]);
    assign pass_ok_s  = (ent_count_s >= 4'd4) && (ent_count_s <= 4'(PASS_MAX));
    assign user_idx_s = 3'(opt_r - 4'd5);

    // Working copy with the pending entry applied to the current option
    always_comb begin
        work_commit_s = work_r;
        if (ent_count_s == 4'd0) begin
            work_commit_s = work_r;
        end else begin
            case (opt_r)
                4'd1: work_commit_s.bip_status = (ent_digits_s[0] != 4'd0);
                4'd2: work_commit_s.bip_time = clamp7(num_s, 7'(BIP_MIN), 7'(BIP_MAX));
                4'd3: work_commit_s.tranca_aut_time =
                          clamp7(num_s, 7'(TRANCA_MIN), 7'(TRANCA_MAX));
                4'd4: begin
                    if (pass_ok_s) begin
                        work_commit_s.senha_master = ent_digits_s;
                    end else begin
                        work_commit_s.senha_master = work_r.senha_master;
                    end
                end
                default: begin
                    if ((opt_r >= 4'd5) && (opt_r <= LAST_OPT) && pass_ok_s) begin
                        work_commit_s.senha_user[user_idx_s] = ent_digits_s;
                    end else begin
                        work_commit_s = work_r;
                    end
                end
            endcase
        end
    end

    // Session FSM with registered display, configuration and strobe outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_IDLE;
            opt_r        <= 4'd0;
            work_r       <= setup_default();
            setup_r      <= setup_default();
            bcd_r        <= BCD_BLANK;
            display_en_r <= 1'b0;
            ok_r         <= 1'b0;
        end else begin
            ok_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (setup_on) begin
                        work_r       <= setup_r;
                        display_en_r <= 1'b1;
                        bcd_r        <= BCD_BLANK;
                        state_r      <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (timeout_s) begin
                        display_en_r <= 1'b0;
                        bcd_r        <= BCD_BLANK;
                        state_r      <= S_IDLE;
                    end else if (key_a_s) begin
                        opt_r   <= 4'd1;
                        bcd_r   <= {4'd1, {5{BLANK}}};
                        state_r <= S_EDIT;
                    end else if (key_b_s) begin
                        state_r <= S_COMMIT;
                    end
                end
                S_EDIT: begin
                    if (timeout_s) begin
                        display_en_r <= 1'b0;
                        bcd_r        <= BCD_BLANK;
                        state_r      <= S_IDLE;
                    end else if (key_a_s) begin
                        work_r <= work_commit_s;
                        opt_r  <= opt_next_s;
                        bcd_r  <= {opt_next_s, {5{BLANK}}};
                    end else if (key_b_s) begin
                        state_r <= S_COMMIT;
                    end else if (key_digit_s) begin
                        bcd_r[4:0] <= view_nxt_s;
                    end
                end
                S_COMMIT: begin
                    work_r  <= work_commit_s;
                    state_r <= S_DONE;
                end
                S_DONE: begin
                    setup_r      <= work_r;
                    ok_r         <= 1'b1;
                    display_en_r <= 1'b0;
                    bcd_r        <= BCD_BLANK;
                    state_r      <= S_IDLE;
                end
                default: begin
                    display_en_r <= 1'b0;
                    bcd_r        <= BCD_BLANK;
                    state_r      <= S_IDLE;
                end
            endcase
        end
    end

    assign display_en     = display_en_r;
    assign bcd_pac        = bcd_r;
    assign data_setup_new = setup_r;
    assign data_setup_ok  = ok_r;

endmodule

// File: tb/tb_setup_param.sv
// Directed bench for setup_param: a table of keypad sessions with hand-computed
// results plus hand-written sequences for display, wrap, overflow and reset.
module tb_setup_param;
    import setup_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       setup_on;
    logic [3:0] digitos_value;
    logic       digitos_valid;
    logic       display_en;
    logic       data_setup_ok;
    bcdPac_t    bcd_pac;
    setupPac_t  data_setup_new;

    int total = 0;
    int bad   = 0;
    setupPac_t exp_cfg;

    typedef struct {
        string       nm;
        int          n;
        logic [47:0] seq;
        int          f1;
        logic [47:0] v1;
        int          f2;
        logic [47:0] v2;
    } vec_t;

    vec_t tbl [14];

    setup_param dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .setup_on       (setup_on),
        .digitos_value  (digitos_value),
        .digitos_valid  (digitos_valid),
        .display_en     (display_en),
        .bcd_pac        (bcd_pac),
        .data_setup_new (data_setup_new),
        .data_setup_ok  (data_setup_ok)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    function automatic setupPac_t dflt();
        setupPac_t s;
        s.bip_status      = 1'b1;
        s.bip_time        = 7'd5;
        s.tranca_aut_time = 7'd5;
        s.senha_master    = 48'hFFFF_FFFF_1234;
        for (int i = 0; i < 8; i++) s.senha_user[i] = 48'hFFFF_FFFF_FFFF;
        return s;
    endfunction

    function automatic setupPac_t set_fld(setupPac_t s, int f, logic [47:0] v);
        setupPac_t r;
        r = s;
        case (f)
            0: r.bip_status      = v[0];
            1: r.bip_time        = v[6:0];
            2: r.tranca_aut_time = v[6:0];
            3: r.senha_master    = v;
            4: r.senha_user[0]   = v;
            default: r = s;
        endcase
        return r;
    endfunction

    function automatic vec_t mk(string nm, int n, logic [47:0] seq, int f1, logic [47:0] v1,
                                int f2, logic [47:0] v2);
        vec_t v;
        v.nm = nm; v.n = n; v.seq = seq; v.f1 = f1; v.v1 = v1; v.f2 = f2; v.v2 = v2;
        return v;
    endfunction

    task automatic chk(string nm, logic [47:0] act, logic [47:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_cfg(string nm, setupPac_t act, setupPac_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic key(logic [3:0] v);
        @(negedge clk);
        digitos_value = v;
        digitos_valid = 1'b1;
        @(negedge clk);
        digitos_valid = 1'b0;
        digitos_value = 4'h0;
    endtask

    task automatic pulse_setup();
        @(negedge clk);
        setup_on = 1'b1;
        @(negedge clk);
        setup_on = 1'b0;
    endtask

    // Presses B and counts data_setup_ok cycles over a fixed window
    task automatic close_b(output int pulses);
        key(KEY_B);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (data_setup_ok) pulses++;
        end
    endtask

    initial begin
        int p;
        logic [47:0] s;
        rst_n = 1'b1; setup_on = 1'b0; digitos_valid = 1'b0; digitos_value = 4'h0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_display_en", 48'(display_en), 48'd0);
        chk("rst_ok", 48'(data_setup_ok), 48'd0);
        chk("rst_bcd", 48'(bcd_pac), 48'hFF_FFFF);
        exp_cfg = dflt();
        chk_cfg("rst_cfg", data_setup_new, exp_cfg);
        @(negedge clk);
        rst_n = 1'b1;

        // Entry display and option latency
        pulse_setup();
        chk("armed_display_en", 48'(display_en), 48'd1);
        key(KEY_A);
        chk("edit_opt1", 48'(bcd_pac), 48'h1F_FFFF);
        key(4'd1); key(4'd2); key(4'd3);
        chk("edit_123", 48'(bcd_pac), 48'h1F_F123);
        key(4'd4); key(4'd5); key(4'd6); key(4'd7); key(4'd8);
        chk("edit_last5", 48'(bcd_pac), 48'h14_5678);
        key(KEY_A);
        chk("edit_opt2", 48'(bcd_pac), 48'h2F_FFFF);
        chk_cfg("cfg_hold_before_done", data_setup_new, exp_cfg);
        close_b(p);
        chk("seq1_ok_pulses", 48'(p), 48'd1);
        chk("seq1_display_off", 48'(display_en), 48'd0);
        chk_cfg("seq1_cfg", data_setup_new, exp_cfg);

        // Option wrap after 4+NUM_USERS+1 presses
        pulse_setup();
        for (int i = 1; i <= 9; i++) begin
            key(KEY_A);
            if (i == 8) chk("wrap_last_opt", 48'(bcd_pac), 48'h8F_FFFF);
        end
        chk("wrap_to_1", 48'(bcd_pac), 48'h1F_FFFF);
        close_b(p);
        chk("wrap_ok_pulses", 48'(p), 48'd1);

        // Ignored keys, digits in ARMED, setup_on while busy
        pulse_setup();
        key(4'd5);
        chk("armed_digit_ignored", 48'(bcd_pac), 48'hFF_FFFF);
        key(KEY_A);
        key(4'hC); key(4'hD); key(4'hE); key(4'hF);
        chk("keys_c_f_ignored", 48'(bcd_pac), 48'h1F_FFFF);
        pulse_setup();
        key(4'd2);
        chk("setup_on_ignored", 48'(bcd_pac), 48'h1F_FFF2);
        close_b(p);
        chk_cfg("ignored_cfg", data_setup_new, exp_cfg);

        tbl[0]  = mk("bt_clamp_lo",  5, 48'hAA03B,       1, 48'd5,  -1, 48'd0);
        tbl[1]  = mk("bt_clamp_hi",  5, 48'hAA97B,       1, 48'd60, -1, 48'd0);
        tbl[2]  = mk("bt_mid",       5, 48'hAA25B,       1, 48'd25, -1, 48'd0);
        tbl[3]  = mk("bt_last2",     6, 48'hAA142B,      1, 48'd42, -1, 48'd0);
        tbl[4]  = mk("bs_zero",      3, 48'hA0B,         0, 48'd0,  -1, 48'd0);
        tbl[5]  = mk("bs_nonzero",   4, 48'hA07B,        0, 48'd1,  -1, 48'd0);
        tbl[6]  = mk("tt_clamp_hi",  6, 48'hAAA99B,      2, 48'd60, -1, 48'd0);
        tbl[7]  = mk("tt_empty",     4, 48'hAAAB,        2, 48'd60, -1, 48'd0);
        tbl[8]  = mk("tt_one_digit", 5, 48'hAAA8B,       2, 48'd8,  -1, 48'd0);
        tbl[9]  = mk("pw_short",     8, 48'hAAAA987B,    3, 48'hFFFF_FFFF_1234, -1, 48'd0);
        tbl[10] = mk("pw_ok",        9, 48'hAAAA5678B,   3, 48'hFFFF_FFFF_5678, -1, 48'd0);
        tbl[11] = mk("user1",       11, 48'hAAAAA43210B, 4, 48'hFFFF_FFF4_3210, -1, 48'd0);
        tbl[12] = mk("armed_b",      1, 48'hB,           1, 48'd42, -1, 48'd0);
        tbl[13] = mk("two_fields",   8, 48'hAA55A10B,    1, 48'd55,  2, 48'd10);

        for (int r = 0; r < 14; r++) begin
            exp_cfg = set_fld(exp_cfg, tbl[r].f1, tbl[r].v1);
            exp_cfg = set_fld(exp_cfg, tbl[r].f2, tbl[r].v2);
            s = tbl[r].seq;
            pulse_setup();
            for (int k = tbl[r].n - 1; k > 0; k--) key(s[4*k +: 4]);
            close_b(p);
            chk({tbl[r].nm, "_ok_pulses"}, 48'(p), 48'd1);
            chk_cfg(tbl[r].nm, data_setup_new, exp_cfg);
        end

        // Password overflow keeps the first 12 digits
        pulse_setup();
        for (int i = 0; i < 4; i++) key(KEY_A);
        for (int i = 1; i <= 14; i++) key(4'(i % 10));
        close_b(p);
        exp_cfg = set_fld(exp_cfg, 3, 48'h1234_5678_9012);
        chk_cfg("pw_overflow", data_setup_new, exp_cfg);

        // Long inactivity
        pulse_setup();
        key(KEY_A);
        p = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (data_setup_ok) p++;
        end
`ifdef SETUP_TIMEOUT_EN
        chk("timeout_display_off", 48'(display_en), 48'd0);
        chk("timeout_no_ok", 48'(p), 48'd0);
        chk_cfg("timeout_cfg", data_setup_new, exp_cfg);
`else
        chk("persist_display_on", 48'(display_en), 48'd1);
        chk("persist_bcd", 48'(bcd_pac), 48'h1F_FFFF);
        close_b(p);
        chk("persist_ok_pulses", 48'(p), 48'd1);
        chk_cfg("persist_cfg", data_setup_new, exp_cfg);
`endif

        // Asynchronous reset in the middle of an edit
        pulse_setup();
        key(KEY_A); key(KEY_A); key(4'd9); key(4'd9);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_display_en", 48'(display_en), 48'd0);
        chk("midrst_bcd", 48'(bcd_pac), 48'hFF_FFFF);
        exp_cfg = dflt();
        chk_cfg("midrst_cfg", data_setup_new, exp_cfg);
        @(negedge clk);
        rst_n = 1'b1;
        pulse_setup();
        close_b(p);
        chk_cfg("after_rst_cfg", data_setup_new, exp_cfg);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
